// File: rtl/ble_pkg.sv
// Shared types and constants for the AT command sequencer and its response matcher.
package ble_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    WAIT_RESP,
    DONE,
    FAIL
  } seq_state_t;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] NUL = 8'h00;

  localparam int DEF_MEM_DEPTH      = 64;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
  localparam int DEF_MAX_RETRIES    = 2;

  // Expected character at a line position for "OK\r" and "ERROR\r".
  function automatic logic [7:0] ok_char(input logic [2:0] pos);
    case (pos)
      3'd0:    return 8'h4F;
      3'd1:    return 8'h4B;
      default: return CR;
    endcase
  endfunction

  function automatic logic [7:0] err_char(input logic [2:0] pos);
    case (pos)
      3'd0:    return 8'h45;
      3'd1:    return 8'h52;
      3'd2:    return 8'h52;
      3'd3:    return 8'h4F;
      3'd4:    return 8'h52;
      default: return CR;
    endcase
  endfunction

endpackage

// File: rtl/at_resp_matcher.sv
// Line matcher: pulses ok/err one cycle after the LF of an exact "OK\r" / "ERROR\r" line.
module at_resp_matcher
  import ble_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ok,
  output logic       err
);

  logic [2:0] pos;
  logic       ok_live;
  logic       err_live;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pos      <= 3'd0;
      ok_live  <= 1'b1;
      err_live <= 1'b1;
      ok       <= 1'b0;
      err      <= 1'b0;
    end else begin
      ok  <= 1'b0;
      err <= 1'b0;
      if (rx_valid) begin
        if (rx_data == LF) begin
          ok       <= ok_live && (pos == 3'd3);
          err      <= err_live && (pos == 3'd6);
          pos      <= 3'd0;
          ok_live  <= 1'b1;
          err_live <= 1'b1;
        end else begin
          // A live flag dies on the first wrong or surplus character.
          ok_live  <= ok_live && (pos < 3'd3) && (rx_data == ok_char(pos));
          err_live <= err_live && (pos < 3'd6) && (rx_data == err_char(pos));
          if (pos != 3'd7) pos <= pos + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/at_cmd_sequencer.sv
// Sends LF-terminated AT commands from a byte memory and waits for OK/ERROR with retry and timeout.
module at_cmd_sequencer
  import ble_pkg::*;
#(
  parameter  int MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int MAX_RETRIES    = DEF_MAX_RETRIES,
  localparam int ADDR_W         = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              tx_full,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic [7:0]        cmd_index,
  output logic              setup_done,
  output logic              fail,
  output logic [2:0]        dbg_state
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  seq_state_t         state, state_n;
  logic [ADDR_W-1:0]  addr, addr_n, cmd_start, cmd_start_n;
  logic [7:0]         idx, idx_n, data_q, data_n;
  logic [RETRY_W-1:0] retries, retries_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               match_clear, ok, err;

  at_resp_matcher u_matcher (
    .clk      (clk),
    .rst      (rst),
    .clear    (match_clear),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .ok       (ok),
    .err      (err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      cmd_start <= '0;
      idx       <= 8'd0;
      data_q    <= 8'd0;
      retries   <= '0;
      timer     <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cmd_start <= cmd_start_n;
      idx       <= idx_n;
      data_q    <= data_n;
      retries   <= retries_n;
      timer     <= timer_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cmd_start_n = cmd_start;
    idx_n       = idx;
    data_n      = data_q;
    retries_n   = retries;
    timer_n     = timer;
    match_clear = 1'b0;
    tx_valid    = 1'b0;
    case (state)
      IDLE: if (start) begin
        addr_n      = '0;
        cmd_start_n = '0;
        idx_n       = 8'd0;
        retries_n   = '0;
        state_n     = FETCH;
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        data_n  = mem_data;
        state_n = (addr == cmd_start && mem_data == NUL) ? DONE : SEND;
      end
      SEND: begin
        tx_valid = !tx_full;
        if (!tx_full) begin
          if (data_q == LF) begin
            timer_n     = '0;
            match_clear = 1'b1;
            state_n     = WAIT_RESP;
          end else if (addr == LAST_ADDR) begin
            state_n = FAIL;
          end else begin
            addr_n  = addr + 1'b1;
            state_n = FETCH;
          end
        end
      end
      WAIT_RESP: begin
        timer_n = timer + 1'b1;
        // ok takes priority over a same-cycle err or timeout.
        if (ok) begin
          if (addr == LAST_ADDR) begin
            state_n = FAIL;
          end else begin
            addr_n      = addr + 1'b1;
            cmd_start_n = addr + 1'b1;
            idx_n       = idx + 8'd1;
            retries_n   = '0;
            state_n     = FETCH;
          end
        end else if (err || timer == TMO_LAST) begin
          if (retries == RETRY_MAX) begin
            state_n = FAIL;
          end else begin
            retries_n = retries + 1'b1;
            addr_n    = cmd_start;
            state_n   = FETCH;
          end
        end
      end
      DONE:    state_n = IDLE;
      FAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) tx_valid = 1'b0;
  end

  assign mem_addr   = addr;
  assign tx_data    = data_q;
  assign cmd_index  = idx;
  assign busy       = (state != IDLE);
  assign setup_done = (state == DONE) && !abort;
  assign fail       = (state == FAIL) && !abort;
  assign dbg_state  = state;

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Bench for at_cmd_sequencer: a transaction-level model predicts the TX byte stream and outcome.
module tb_at_cmd_sequencer;
  import ble_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TMO   = 100;
  localparam int RETR  = 2;

  localparam int R_OK = 0, R_ERR = 1, R_SILENT = 2, R_ECHO = 3, R_URC = 4, R_JUNK = 5, R_EDGE = 6;

  logic          clk, rst, start, abort, tx_full, rx_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data, tx_data, rx_data, cmd_index;
  logic          tx_valid, busy, setup_done, fail;
  logic [2:0]    dbg_state;

  at_cmd_sequencer #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_addr(mem_addr),
    .mem_data(mem_data), .tx_full(tx_full), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .cmd_index(cmd_index),
    .setup_done(setup_done), .fail(fail), .dbg_state(dbg_state)
  );

  logic [7:0] mem [DEPTH];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int script[$];
  int rsp_q[$];
  int lf_times[$];
  int total = 0, bad = 0;
  int cyc = 0, done_cnt = 0, fail_cnt = 0, full_violations = 0;
  int full_mode = 0;
  int wp;
  int exp_idx;
  bit exp_ok;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_valid) begin
        if (exp_q.size() == 0) check_eq("tx_extra_byte", exp_q.size(), 1);
        else check_eq("tx_byte", tx_data, exp_q.pop_front());
        if (tx_data == LF) lf_times.push_back(cyc);
      end
      if (tx_full && tx_valid) full_violations++;
      if (setup_done) done_cnt++;
      if (fail) fail_cnt++;
    end
  end

  // ---------------- tx_full driver ----------------
  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        2:       tx_full = 1'b1;
        1:       tx_full = ($urandom_range(0, 3) == 0);
        default: tx_full = 1'b0;
      endcase
    end
  end

  // ---------------- responder (modem side) ----------------
  task automatic add_line(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    rx_q.push_back(CR);
    rx_q.push_back(LF);
  endtask

  initial begin
    int kind, gap;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_data == LF) begin
        kind = (rsp_q.size() > 0) ? rsp_q.pop_front() : R_SILENT;
        // The edge case lands the OK's LF so the ok pulse meets the last timeout cycle.
        gap  = (kind == R_EDGE) ? TMO - 4 : $urandom_range(1, 20);
        rx_q.delete();
        case (kind)
          R_OK, R_EDGE: add_line("OK");
          R_ERR:        add_line("ERROR");
          R_ECHO:       begin add_line("AT"); add_line("OK"); end
          R_URC:        begin add_line("+URC: 1"); add_line("OK"); end
          R_JUNK:       add_line("OKAY");
          default:      ;
        endcase
        if (rx_q.size() > 0) begin
          @(posedge clk);
          repeat (gap - 1) @(posedge clk);
          #1;
          while (rx_q.size() > 0) begin
            rx_valid = 1'b1;
            rx_data  = rx_q.pop_front();
            @(posedge clk);
            #1;
          end
          rx_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit good_reply(input int r);
    return (r == R_OK || r == R_ECHO || r == R_URC || r == R_EDGE);
  endfunction

  task automatic build_expect();
    int pos, p, s, attempt, r;
    bit fin, advanced, got_lf;
    exp_q.delete();
    pos = 0; s = 0; exp_idx = 0; exp_ok = 0; fin = 0;
    while (!fin) begin
      if (mem[pos] == 8'h00) begin
        exp_ok = 1; fin = 1;
      end else begin
        attempt = 0; advanced = 0;
        while (!fin && !advanced) begin
          p = pos; got_lf = 0;
          while (!got_lf && !fin) begin
            exp_q.push_back(mem[p]);
            if (mem[p] == LF) got_lf = 1;
            else if (p == DEPTH - 1) fin = 1;
            else p++;
          end
          if (!fin) begin
            r = (s < script.size()) ? script[s] : R_SILENT;
            s++;
            if (good_reply(r)) begin
              if (p == DEPTH - 1) fin = 1;
              else begin pos = p + 1; exp_idx++; advanced = 1; end
            end else begin
              attempt++;
              if (attempt > RETR) fin = 1;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    wp = 0;
  endtask

  task automatic put_cmd(input string s);
    for (int i = 0; i < s.len(); i++) begin mem[wp] = s[i]; wp++; end
    mem[wp] = CR; wp++;
    mem[wp] = LF; wp++;
  endtask

  task automatic launch(input bit extra_start);
    build_expect();
    rsp_q = script;
    done_cnt = 0; fail_cnt = 0;
    lf_times.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (extra_start) begin
      repeat (6) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic finish_seq(input string tag, input int budget);
    int n = 0;
    while (done_cnt + fail_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq({tag, "_ended"}, (done_cnt + fail_cnt) != 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, done_cnt, exp_ok ? 1 : 0);
    check_eq({tag, "_fail_pulses"}, fail_cnt, exp_ok ? 0 : 1);
    check_eq({tag, "_bytes_left"}, exp_q.size(), 0);
    check_eq({tag, "_cmd_index"}, cmd_index, exp_idx);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, g, ncmd, len, nscr, sz0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_cmd_index", cmd_index, 0);
    check_eq("rst_pulses", {setup_done, fail}, 0);
    rst = 1'b0;

    // single command, OK
    clear_mem(); put_cmd("AT");
    script = '{R_OK};
    launch(0);
    finish_seq("single_ok", 500);

    // ERROR then OK twice; a start while busy must be ignored
    clear_mem(); put_cmd("AT"); put_cmd("ATE0");
    script = '{R_ERR, R_OK, R_OK};
    launch(1);
    finish_seq("err_retry", 800);

    // silence: three sends spaced by the timeout, then fail
    clear_mem(); put_cmd("AT");
    script = '{};
    launch(0);
    finish_seq("timeout", 1000);
    check_eq("timeout_sends", lf_times.size(), 3);
    if (lf_times.size() >= 2) begin
      g = lf_times[1] - lf_times[0];
      check_eq("timeout_gap_in_range", (g >= TMO && g <= TMO + 20), 1);
    end

    // tx_full held high for 20 cycles mid-command
    clear_mem(); put_cmd("AT+CFUN=1");
    script = '{R_OK};
    sz0 = 0;
    launch(0);
    sz0 = exp_q.size();
    n = 0;
    while (exp_q.size() > sz0 - 3 && n < 200) begin @(posedge clk); n++; end
    full_violations = 0;
    full_mode = 2;
    repeat (21) @(posedge clk);
    check_eq("hold_no_progress", exp_q.size() <= sz0 - 3 && exp_q.size() >= sz0 - 4, 1);
    full_mode = 0;
    check_eq("hold_tx_valid_low", full_violations, 0);
    finish_seq("hold", 500);

    // echo of the command before OK
    clear_mem(); put_cmd("AT");
    script = '{R_ECHO};
    launch(0);
    finish_seq("echo", 500);

    // abort while waiting for a response
    clear_mem(); put_cmd("AT");
    script = '{};
    launch(0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[i]);
    n = 0;
    while (lf_times.size() == 0 && n < 300) begin @(posedge clk); n++; end
    check_eq("abort_reached_wait", lf_times.size() > 0, 1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("abort_idle_next", busy, 0);
    repeat (TMO + 40) @(posedge clk);
    #1;
    check_eq("abort_no_pulses", done_cnt + fail_cnt, 0);
    check_eq("abort_no_resend", lf_times.size(), 1);
    check_eq("abort_busy", busy, 0);

    // no LF or NUL anywhere: fail after the last address
    clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(32'h20, 32'h7E));
    script = '{};
    launch(0);
    finish_seq("no_lf", 1000);

    // LF at the last address answered OK still fails
    clear_mem();
    for (int i = 0; i < DEPTH - 1; i++) mem[i] = 8'h41;
    mem[DEPTH - 1] = LF;
    script = '{R_OK};
    launch(0);
    finish_seq("lf_at_end", 1000);

    // ok coinciding with the timeout cycle
    clear_mem(); put_cmd("AT"); put_cmd("AT+X");
    script = '{R_EDGE, R_EDGE};
    launch(0);
    finish_seq("ok_vs_timeout", 1000);

    // randomized command lists, replies and backpressure
    for (int it = 0; it < 20; it++) begin
      clear_mem();
      ncmd = $urandom_range(1, 4);
      for (int c = 0; c < ncmd; c++) begin
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin mem[wp] = 8'($urandom_range(65, 90)); wp++; end
        mem[wp] = CR; wp++;
        mem[wp] = LF; wp++;
      end
      script.delete();
      nscr = $urandom_range(0, 12);
      for (int j = 0; j < nscr; j++) begin
        g = $urandom_range(0, 9);
        script.push_back(g < 4 ? R_OK : (g < 7 ? g - 3 : g - 3));
      end
      full_mode = $urandom_range(0, 1);
      launch(0);
      finish_seq("rand", 3000);
      full_mode = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
